serin_shift_module: RTL and testbench
=====================================

Name: serin_shift_module

Overview:
- POKEY serial-input receiver. It is the receive-side counterpart of the SEROUT shifter.
- Deserialises the SID line into the SERIN register using a 10-bit frame: start 0, data bits 0..7 LSB first, stop 1.
- Generates the serial-input-ready interrupt request and the SKSTAT framing-error and overrun flags.
- Bit timing comes from an external sample strobe (channel-4 timer); an optional async mode requests timer resync at each start edge.

Parameters:
- SYNC_STAGES, 2, number of flops in the SID input synchroniser (allowed values 2..3).

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- reset  input  1  asynchronous, active-high reset.
- enp  input  1  phase enable; state machine and flags advance only when enp=1.
- Sample  input  1  mid-bit sample strobe; acted on only when enp=1.
- SID  input  1  raw serial line; idles high.
- ReadAck  input  1  one-cycle pulse when the CPU reads SERIN.
- ResetSK  input  1  SKRES write; clears FrameErr and Overrun.
- SerinData  output  8  last received data byte.
- DataReady  output  1  one-clk pulse when a byte is loaded into SerinData.
- FrameErr  output  1  sticky framing-error flag.
- Overrun  output  1  sticky overrun flag.
- Busy  output  1  high while a frame is being received (any state other than IDLE).
- SyncReq  output  1  one-clk pulse requesting a timer restart (async feature only).

Behaviour:
- Reset (async, immediate):
  - Outputs: SerinData=8'h00, DataReady=0, FrameErr=0, Overrun=0, Busy=0, SyncReq=0.
  - Internal: state=IDLE, shift register=0, bit count=0, pending=0.
  - Synchroniser flops reset to 1 (line idle).
- Input synchronisation: SID passes through SYNC_STAGES flops clocked every clk; sid_s is the synchroniser output. SID-to-sid_s latency is SYNC_STAGES clk.
- An "event" is a clk edge with enp=1 and Sample=1. The state machine advances only on events:
  - IDLE: event with sid_s=0 -> DATA, bit count=0. Event with sid_s=1 -> stay in IDLE.
  - DATA: each event right-shifts sid_s into bit 7 of the shift register (LSB first) and increments the bit count. On the 8th event -> STOP.
  - STOP: on the event:
    - SerinData <= shift register and DataReady=1 for exactly one clk.
    - FrameErr <= 1 if sid_s=0.
    - Overrun <= 1 if pending=1 when the byte loads; pending <= 1.
    - Then -> IDLE.
- The byte is loaded at the STOP event even when a framing error is flagged. The STOP-to-IDLE transition takes 0 idle cycles, so a start bit at the next event is accepted.
- pending is cleared by ReadAck. If ReadAck and the STOP load occur in the same clk:
  - Overrun is evaluated against pending before the clear.
  - pending ends at 1 (the load wins).
- ResetSK clears FrameErr and Overrun on the next clk, independent of enp. If ResetSK coincides with a STOP event that would set a flag, the set wins.
- ResetSK does not affect the state machine, SerinData or pending.
- Sample while enp=0 is ignored. Reset asserted mid-frame discards the partial byte.
- Busy=1 in DATA and STOP.

Optional Feature:
- Macro: SERIN_ASYNC_EN.
- With the macro defined:
  - In IDLE, a 1->0 transition of sid_s on any clk with enp=1 pulses SyncReq for one clk.
  - The next event is then treated as the start-bit centre and is taken as the IDLE start-bit check: sid_s=0 -> DATA.
  - Falling edges outside IDLE are ignored.
- Without the macro: SyncReq is held at 0 and no edge detector is built.

Test Plan:
- Clean frame: send 0,0x5A LSB first,1 with one Sample per bit -> SerinData=8'h5A, DataReady one clk, FrameErr=0, Overrun=0, Busy low afterwards.
- Framing error: send byte 0xC3 with stop bit 0 -> SerinData=8'hC3, FrameErr=1 held until a ResetSK pulse, then 0.
- Overrun: receive 0x11, no ReadAck, then receive 0x22 -> Overrun=1, SerinData=8'h22. Repeat with ReadAck between the bytes -> Overrun=0.
- Simultaneous events: ReadAck on the same clk as the STOP load of the second byte -> Overrun=1, and pending still set (a third byte without ReadAck keeps Overrun=1).
- Reset and enp gating: assert reset after 4 data bits -> all outputs return to reset values immediately; next full frame 0xFF is received correctly. Sample pulses with enp=0 leave state unchanged.
- SERIN_ASYNC_EN: SID falls while idle -> SyncReq pulses once, SYNC_STAGES clk later. A falling edge mid-frame gives no SyncReq. Without the macro SyncReq stays 0 throughout.

Source files
------------

// File: rtl/serin_shift_module.sv
// serin_shift_module: POKEY serial-input receiver (SID -> SERIN).
// Receives a 10-bit frame (start 0, 8 data bits LSB first, stop 1), one
// bit per sample event (enp & Sample). It raises a DataReady pulse for
// each byte and keeps sticky FrameErr and Overrun flags.
// Optional build macro SERIN_ASYNC_EN: when defined, SyncReq pulses on an
// idle-line falling edge so the bit timer can resync to the start bit.
// When it is undefined, SyncReq is tied low.
module serin_shift_module #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enp,
  input  logic       Sample,
  input  logic       SID,
  input  logic       ReadAck,
  input  logic       ResetSK,
  output logic [7:0] SerinData,
  output logic       DataReady,
  output logic       FrameErr,
  output logic       Overrun,
  output logic       Busy,
  output logic       SyncReq
);

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [7:0]             shift_q;
  logic [2:0]             bit_cnt;
  logic                   pending;
  logic                   sid_s;
  logic                   evt;
  logic                   stop_evt;

  assign sid_s    = sync_q[SYNC_STAGES-1];
  assign evt      = enp & Sample;
  assign stop_evt = evt && (state == STOP);
  assign Busy     = (state != IDLE);

  // Line synchroniser; it resets to the idle (high) level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], SID};
  end

  // Frame state machine: start check, data shift, stop load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_q   <= 8'h00;
      bit_cnt   <= 3'd0;
      SerinData <= 8'h00;
      DataReady <= 1'b0;
    end else begin
      DataReady <= 1'b0;
      if (evt) begin
        unique case (state)
          IDLE: if (!sid_s) begin
            state   <= DATA;
            bit_cnt <= 3'd0;
          end
          DATA: begin
            shift_q <= {sid_s, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end
          STOP: begin
            // The byte is loaded even when the stop bit is bad.
            SerinData <= shift_q;
            DataReady <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Unread-byte tracking and sticky flags. A set from the stop event
  // wins over ResetSK, and a load wins over ReadAck.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= 1'b0;
      FrameErr <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      if (stop_evt)     pending <= 1'b1;
      else if (ReadAck) pending <= 1'b0;

      if (stop_evt && !sid_s) FrameErr <= 1'b1;
      else if (ResetSK)       FrameErr <= 1'b0;

      if (stop_evt && pending) Overrun <= 1'b1;
      else if (ResetSK)        Overrun <= 1'b0;
    end
  end

`ifdef SERIN_ASYNC_EN
  logic fall_next;
  // sid_s is high now and will be low after this edge, so SyncReq rises
  // in the same cycle that sid_s falls.
  assign fall_next = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-2];

  // Timer resync request on an idle-line start edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) SyncReq <= 1'b0;
    else       SyncReq <= enp && (state == IDLE) && fall_next;
  end
`else
  assign SyncReq = 1'b0;
`endif

endmodule

// File: tb/tb_serin_shift_module.sv
// Self-checking bench for serin_shift_module. Expected bytes are queued
// when a frame is driven and compared whenever DataReady is seen.
module tb_serin_shift_module;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       reset, enp, Sample, SID, ReadAck, ResetSK;
  logic [7:0] SerinData;
  logic       DataReady, FrameErr, Overrun, Busy, SyncReq;

  int         n_checks = 0;
  int         n_errs   = 0;
  int         dr_cnt   = 0;
  int         exp_dr   = 0;
  int         sync_cnt = 0;
  logic [7:0] exp_q[$];

  serin_shift_module #(.SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .enp(enp), .Sample(Sample), .SID(SID),
    .ReadAck(ReadAck), .ResetSK(ResetSK), .SerinData(SerinData),
    .DataReady(DataReady), .FrameErr(FrameErr), .Overrun(Overrun),
    .Busy(Busy), .SyncReq(SyncReq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: each DataReady pulse consumes one queued byte.
  always @(negedge clk) begin
    if (SyncReq) sync_cnt++;
    if (DataReady) begin
      dr_cnt++;
      if (exp_q.size() == 0) chk("unexpected_byte", {24'h0, SerinData}, 32'hFFFF_FFFF);
      else chk("serin_data", {24'h0, SerinData}, {24'h0, exp_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bit: let SID settle through the synchroniser, then one sample event.
  // In gated mode, an enp=0 sample of the inverted bit comes first. It must
  // be ignored.
  task automatic send_bit(input logic b, input logic ack, input logic gated);
    if (gated) begin
      SID = ~b;
      repeat (SS + 1) tick();
      enp = 1'b0; Sample = 1'b1;
      tick();
      Sample = 1'b0; enp = 1'b1;
    end
    SID = b;
    repeat (SS + 1) tick();
    Sample = 1'b1; ReadAck = ack;
    tick();
    Sample = 1'b0; ReadAck = 1'b0;
  endtask

  task automatic send_tail(input logic [7:0] d, input logic stop_b,
                           input logic ack_stop, input logic gated);
    for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0, gated);
    send_bit(stop_b, ack_stop, gated);
    SID = 1'b1;
    repeat (2) tick();
    chk("dready_count", dr_cnt, exp_dr);
    chk("busy_after_frame", {31'h0, Busy}, 32'h0);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b,
                            input logic ack_stop, input logic gated);
    exp_q.push_back(d);
    exp_dr++;
    send_bit(1'b0, 1'b0, gated);
    send_tail(d, stop_b, ack_stop, gated);
  endtask

  task automatic pulse_ack();
    ReadAck = 1'b1; tick(); ReadAck = 1'b0;
  endtask

  task automatic pulse_sk();
    enp = 1'b0; ResetSK = 1'b1; tick(); ResetSK = 1'b0; enp = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_data"}, {24'h0, SerinData}, 32'h0);
    chk({tag, "_flags"}, {26'h0, DataReady, FrameErr, Overrun, Busy, SyncReq, 1'b0}, 32'h0);
  endtask

  initial begin
    int s0;
    reset = 1'b1; enp = 1'b1; Sample = 1'b0; SID = 1'b1;
    ReadAck = 1'b0; ResetSK = 1'b0;
    repeat (3) tick();
    chk_reset_vals("reset");
    reset = 1'b0;
    repeat (3) tick();

    // Clean frame.
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    chk("clean_ferr", {31'h0, FrameErr}, 32'h0);
    chk("clean_ovr", {31'h0, Overrun}, 32'h0);
    pulse_ack();

    // Framing error: sticky until ResetSK, which works with enp low.
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
    chk("ferr_set", {31'h0, FrameErr}, 32'h1);
    pulse_ack();
    repeat (4) tick();
    chk("ferr_sticky", {31'h0, FrameErr}, 32'h1);
    pulse_sk();
    chk("ferr_cleared", {31'h0, FrameErr}, 32'h0);

    // Overrun without a read between the bytes.
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    chk("ovr_first", {31'h0, Overrun}, 32'h0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    chk("ovr_set", {31'h0, Overrun}, 32'h1);
    pulse_sk();
    chk("ovr_cleared", {31'h0, Overrun}, 32'h0);
    pulse_ack();

    // A read between the bytes prevents overrun.
    send_frame(8'h33, 1'b1, 1'b0, 1'b0);
    pulse_ack();
    send_frame(8'h44, 1'b1, 1'b0, 1'b0);
    chk("ovr_with_ack", {31'h0, Overrun}, 32'h0);

    // ReadAck on the stop load: overrun uses the old pending, and the load keeps pending set.
    send_frame(8'h55, 1'b1, 1'b1, 1'b0);
    chk("ovr_simul", {31'h0, Overrun}, 32'h1);
    pulse_sk();
    send_frame(8'h66, 1'b1, 1'b0, 1'b0);
    chk("ovr_pending_kept", {31'h0, Overrun}, 32'h1);
    pulse_sk();
    pulse_ack();

    // enp gating: samples with enp=0 and the line low must not start a frame.
    SID = 1'b0;
    repeat (SS + 1) tick();
    enp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Sample = 1'b1; tick(); Sample = 1'b0; tick();
    end
    enp = 1'b1;
    chk("enp_gate_idle", {31'h0, Busy}, 32'h0);
    SID = 1'b1;
    repeat (SS + 1) tick();
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    pulse_ack();

    // Reset mid-frame drops the partial byte.
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0);
    chk("busy_mid_frame", {31'h0, Busy}, 32'h1);
    #2 reset = 1'b1;
    #1 chk_reset_vals("async_reset");
    tick();
    reset = 1'b0;
    SID = 1'b1;
    repeat (SS + 1) tick();
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    chk("ovr_after_reset", {31'h0, Overrun}, 32'h0);
    pulse_ack();

`ifdef SERIN_ASYNC_EN
    // An idle falling edge pulses SyncReq SS clocks later. Falls inside the frame do not.
    s0 = sync_cnt;
    exp_q.push_back(8'hA5);
    exp_dr++;
    SID = 1'b0;
    repeat (SS - 1) tick();
    chk("syncreq_early", {31'h0, SyncReq}, 32'h0);
    tick();
    chk("syncreq_pulse", {31'h0, SyncReq}, 32'h1);
    tick();
    chk("syncreq_one_clk", {31'h0, SyncReq}, 32'h0);
    Sample = 1'b1; tick(); Sample = 1'b0;
    send_tail(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("syncreq_count", sync_cnt, s0 + 1);
`else
    s0 = 0;
    chk("syncreq_off", sync_cnt, s0);
`endif

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule
